ram_burst: RTL and testbench

RAM_BURST -- requirements
Module: ram_burst

---
 rtl/RAM_pkg.sv | 17 +
 rtl/ram_ptr_wrap.sv | 28 ++
 rtl/ram_burst.sv | 157 +++++++++++++++
 tb/tb_ram_burst.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/RAM_pkg.sv
// Shared types for the burst RAM: command codes
// and the burst controller state encoding.
package RAM_pkg;

  typedef enum logic [1:0] {
    STORE_WR_ADDR = 2'b00,
    WRITE_DATA    = 2'b01,
    STORE_RD_ADDR = 2'b10,
    READ_DATA     = 2'b11
  } cmd_e;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

endpackage

// File: rtl/ram_ptr_wrap.sv
// Loadable address pointer that steps by one and
// wraps from DEPTH-1 back to zero.
module ram_ptr_wrap #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             en,
  output logic [WIDTH-1:0] ptr
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(DEPTH - 1);

  // load wins over increment; increment wraps at the last word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= value;
    end else if (en) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ram_burst.sv
// Command-driven RAM with address pointers and
// multi-beat read bursts.
module ram_burst
  import RAM_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8,
  parameter int AUTO_INC  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_valid,
  input  logic [ADDR_SIZE+1:0] din,
  output logic [DATA_SIZE-1:0] dout,
  output logic                 tx_valid,
  output logic                 busy,
  output logic                 err
);

  localparam logic STEP = (AUTO_INC != 0);
  localparam logic [ADDR_SIZE:0] LIMIT =
    (ADDR_SIZE + 1)'(MEM_DEPTH);

  logic [DATA_SIZE-1:0] mem [0:MEM_DEPTH-1];

  state_e               state;
  state_e               state_n;
  cmd_e                 cmd;
  logic [ADDR_SIZE-1:0] payload;
  logic [ADDR_SIZE-1:0] cnt;
  logic [ADDR_SIZE-1:0] cnt_n;
  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic                 oob;
  logic                 accept;
  logic                 beat;
  logic                 mem_we;
  logic                 wr_load;
  logic                 rd_load;
  logic                 wr_inc;
  logic                 rd_inc;
  logic                 err_n;

  assign cmd     = cmd_e'(din[ADDR_SIZE+1:ADDR_SIZE]);
  assign payload = din[ADDR_SIZE-1:0];
  assign oob     = {1'b0, payload} >= LIMIT;
  assign accept  = rx_valid && (state == IDLE) && !rst;
  assign busy    = (state == BURST);
  assign rd_inc  = beat && STEP;

  // decode commands and sequence the burst
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    beat    = 1'b0;
    mem_we  = 1'b0;
    wr_load = 1'b0;
    rd_load = 1'b0;
    wr_inc  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (cmd)
            STORE_WR_ADDR: begin
              err_n   = oob;
              wr_load = !oob;
            end
            WRITE_DATA: begin
              mem_we = 1'b1;
              wr_inc = STEP;
            end
            STORE_RD_ADDR: begin
              err_n   = oob;
              rd_load = !oob;
            end
            READ_DATA: begin
              beat = 1'b1;
              if (payload > ADDR_SIZE'(1)) begin
                state_n = BURST;
                cnt_n   = payload - ADDR_SIZE'(1);
              end
            end
          endcase
        end
      end
      BURST: begin
        beat  = 1'b1;
        err_n = rx_valid;
        cnt_n = cnt - ADDR_SIZE'(1);
        if (cnt == ADDR_SIZE'(1)) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // controller state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // beat counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      dout     <= '0;
      tx_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      cnt      <= cnt_n;
      tx_valid <= beat;
      err      <= err_n;
      if (beat) begin
        dout <= mem[rd_ptr];
      end
    end
  end

  // storage array, deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr] <= payload[DATA_SIZE-1:0];
    end
  end

  ram_ptr_wrap #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (ADDR_SIZE)
  ) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .load  (wr_load),
    .value (payload),
    .en    (wr_inc),
    .ptr   (wr_ptr)
  );

  ram_ptr_wrap #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (ADDR_SIZE)
  ) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .load  (rd_load),
    .value (payload),
    .en    (rd_inc),
    .ptr   (rd_ptr)
  );

endmodule

// File: tb/tb_ram_burst.sv
// Bench for ram_burst: an auto-increment instance
// (200 words) and a static-pointer instance (256).
module tb_ram_burst;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid [2];
  logic [9:0] din      [2];
  logic [7:0] dout     [2];
  logic       tx_valid [2];
  logic       busy     [2];
  logic       err      [2];

  int tests = 0;
  int fails = 0;

  int depth [2] = '{200, 256};
  bit ai    [2] = '{1'b1, 1'b0};

  logic [7:0] mm [2][256];
  int         wp [2];
  int         rp [2];

  always #5 clk = ~clk;

  ram_burst #(
    .MEM_DEPTH (200),
    .ADDR_SIZE (8),
    .DATA_SIZE (8),
    .AUTO_INC  (1)
  ) dut_a (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid[0]),
    .din      (din[0]),
    .dout     (dout[0]),
    .tx_valid (tx_valid[0]),
    .busy     (busy[0]),
    .err      (err[0])
  );

  ram_burst #(
    .MEM_DEPTH (256),
    .ADDR_SIZE (8),
    .DATA_SIZE (8),
    .AUTO_INC  (0)
  ) dut_b (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid[1]),
    .din      (din[1]),
    .dout     (dout[1]),
    .tx_valid (tx_valid[1]),
    .busy     (busy[1]),
    .err      (err[1])
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic send(input int s,
                      input logic [1:0] c,
                      input logic [7:0] p);
    @(negedge clk);
    rx_valid[s] = 1'b1;
    din[s]      = {c, p};
    @(posedge clk);
    #1;
    rx_valid[s] = 1'b0;
  endtask

  task automatic store(input int s, input bit rd,
                       input logic [7:0] p);
    bit oob;
    oob = int'(p) >= depth[s];
    send(s, rd ? 2'b10 : 2'b00, p);
    if (!oob) begin
      if (rd) rp[s] = int'(p);
      else    wp[s] = int'(p);
    end
    chk("store_err", err[s], oob);
    chk("store_txv", tx_valid[s], 0);
  endtask

  task automatic wr(input int s, input logic [7:0] d);
    send(s, 2'b01, d);
    mm[s][wp[s]] = d;
    if (ai[s]) wp[s] = (wp[s] + 1) % depth[s];
    chk("write_err", err[s], 0);
    chk("write_txv", tx_valid[s], 0);
  endtask

  // burst of len beats; a stray command is driven
  // into the edge of beat intr (when intr > 0)
  task automatic rd_burst(input int s, input int len,
                          input int intr);
    int n;
    logic [7:0] last;
    n = (len == 0) ? 1 : len;
    send(s, 2'b11, 8'(len));
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(negedge clk);
        if (i == intr) begin
          rx_valid[s] = 1'b1;
          din[s]      = {2'b01, 8'hEE};
        end
        @(posedge clk);
        #1;
        rx_valid[s] = 1'b0;
      end
      last = mm[s][rp[s]];
      chk("beat_data", dout[s], last);
      chk("beat_txv", tx_valid[s], 1);
      chk("beat_busy", busy[s], i < n - 1);
      chk("beat_err", err[s], i > 0 && i == intr);
      if (ai[s]) rp[s] = (rp[s] + 1) % depth[s];
    end
    @(posedge clk);
    #1;
    chk("post_txv", tx_valid[s], 0);
    chk("post_busy", busy[s], 0);
    chk("post_hold", dout[s], last);
    chk("post_err", err[s], 0);
  endtask

  // 8-beat burst on instance A, reset after beat
  // index 'at', then re-read the same 8 words
  task automatic rst_burst(input logic [7:0] r,
                           input int at);
    store(0, 1'b1, r);
    send(0, 2'b11, 8'd8);
    for (int i = 0; i <= at; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      chk("pre_rst_data", dout[0], mm[0][rp[0]]);
      rp[0] = (rp[0] + 1) % depth[0];
    end
    #2;
    rst = 1'b1;
    #1;
    chk("rst_dout", dout[0], 0);
    chk("rst_txv", tx_valid[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_err", err[0], 0);
    @(negedge clk);
    rst = 1'b0;
    wp[0] = 0; rp[0] = 0;
    wp[1] = 0; rp[1] = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("after_rst_txv", tx_valid[0], 0);
      chk("after_rst_busy", busy[0], 0);
    end
    store(0, 1'b1, r);
    rd_burst(0, 8, -1);
  endtask

  initial begin
    int len;
    int n;
    int intr;
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      rx_valid[s] = 1'b0;
      din[s]      = '0;
      wp[s]       = 0;
      rp[s]       = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("reset_dout", dout[s], 0);
      chk("reset_txv", tx_valid[s], 0);
      chk("reset_busy", busy[s], 0);
      chk("reset_err", err[s], 0);
    end
    @(negedge clk);
    rst = 1'b0;

    // static pointers: overwrite, repeat beats
    store(1, 1'b0, 8'h20);
    wr(1, 8'h77);
    wr(1, 8'h88);
    store(1, 1'b1, 8'h20);
    rd_burst(1, 0, -1);
    rd_burst(1, 3, -1);
    rd_burst(1, 1, -1);

    // fill all of A; pointer wraps back to 0
    store(0, 1'b0, 8'd0);
    for (int i = 0; i < 200; i++) wr(0, 8'($urandom));

    // three-beat burst of known data
    store(0, 1'b0, 8'h10);
    wr(0, 8'hA1);
    wr(0, 8'hB2);
    wr(0, 8'hC3);
    store(0, 1'b1, 8'h10);
    rd_burst(0, 3, -1);

    // wrap at the last word and range rejection
    store(0, 1'b0, 8'd199);
    wr(0, 8'($urandom));
    wr(0, 8'($urandom));
    store(0, 1'b1, 8'd199);
    rd_burst(0, 2, -1);
    store(0, 1'b0, 8'd200);
    store(0, 1'b1, 8'hFF);
    wr(0, 8'h3C);
    store(0, 1'b1, 8'd1);
    rd_burst(0, 1, -1);

    // stray command during a burst
    store(0, 1'b1, 8'd50);
    rd_burst(0, 4, 2);
    store(0, 1'b1, 8'd50);
    rd_burst(0, 5, -1);

    rst_burst(8'd60, 2);

    for (int it = 0; it < 40; it++) begin
      if (it == 20) begin
        rst_burst(8'($urandom_range(0, 199)),
                  $urandom_range(0, 6));
      end
      case ($urandom_range(0, 3))
        0: begin
          store(0, 1'b0, 8'($urandom_range(0, 255)));
          wr(0, 8'($urandom));
        end
        1: store(0, 1'b1, 8'($urandom_range(0, 255)));
        default: begin
          len = $urandom_range(0, 9);
          n = (len == 0) ? 1 : len;
          intr = -1;
          if (n > 1 && $urandom_range(0, 1) == 1)
            intr = $urandom_range(1, n - 1);
          rd_burst(0, len, intr);
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
